// File: rtl/systolic_psum_collector.sv
// Drain-side collector for the bottom row of a weight-stationary systolic array:
// de-skews column psums, accumulates K tiles per row, saturates and queues result rows.
module systolic_psum_collector #(
    parameter int NUM_COL    = 4,
    parameter int BW_ACCU    = 32,
    parameter int BW_OUT     = 16,
    parameter int M_MAX      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [$clog2(M_MAX+1)-1:0]    cfg_rows,
    input  logic [7:0]                    cfg_tiles,
    input  logic [NUM_COL*BW_ACCU-1:0]    psum_in,
    input  logic                          psum_valid,
    output logic [NUM_COL*BW_OUT-1:0]     out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow
);

    localparam int RW      = $clog2(M_MAX + 1);
    localparam int AW      = $clog2(M_MAX);
    localparam int FW      = $clog2(FIFO_DEPTH);
    localparam int ROW_ACC = NUM_COL * BW_ACCU;
    localparam int ROW_OUT = NUM_COL * BW_OUT;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] DRAIN   = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam logic signed [BW_ACCU-1:0] SAT_MAX = {{(BW_ACCU-BW_OUT+1){1'b0}}, {(BW_OUT-1){1'b1}}};
    localparam logic signed [BW_ACCU-1:0] SAT_MIN = {{(BW_ACCU-BW_OUT+1){1'b1}}, {(BW_OUT-1){1'b0}}};

    logic [1:0]          state_q, state_d;
    logic [RW-1:0]       rows_q, rowCnt_q;
    logic [7:0]          tiles_q, tileCnt_q;
    logic                overflow_q;
    logic [NUM_COL-2:0]  vld_q;
    logic [ROW_ACC-1:0]  alignedRow, accRd, sumRow;
    logic [ROW_OUT-1:0]  satRow;
    logic [ROW_ACC-1:0]  acc_q [M_MAX];
    logic [ROW_OUT-1:0]  fifoMem_q [FIFO_DEPTH];
    logic [FW-1:0]       wrPtr_q, rdPtr_q;
    logic [FW:0]         count_q;
    logic                alignedValid, rowFire, firstTile, lastTile, lastRow;
    logic                full, push, pop, drop, accept;

    // Column c waits NUM_COL-1-c cycles so every column lines up with the last one.
    for (genvar c = 0; c < NUM_COL; c++) begin : g_deskew
        localparam int D = NUM_COL - 1 - c;
        if (D == 0) begin : g_direct
            assign alignedRow[c*BW_ACCU +: BW_ACCU] = psum_in[c*BW_ACCU +: BW_ACCU];
        end else begin : g_pipe
            logic [BW_ACCU-1:0] pipe_q [D];
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < D; i++) pipe_q[i] <= '0;
                end else begin
                    pipe_q[0] <= psum_in[c*BW_ACCU +: BW_ACCU];
                    for (int i = 1; i < D; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end
            assign alignedRow[c*BW_ACCU +: BW_ACCU] = pipe_q[D-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= psum_valid;
            for (int i = 1; i < NUM_COL - 1; i++) vld_q[i] <= vld_q[i-1];
        end
    end

    assign alignedValid = vld_q[NUM_COL-2];
    assign rowFire      = (state_q == COLLECT) && alignedValid;
    assign firstTile    = (tileCnt_q == 8'd0);
    assign lastTile     = (tileCnt_q == tiles_q - 8'd1);
    assign lastRow      = (rowCnt_q == rows_q - RW'(1));
    assign accRd        = acc_q[rowCnt_q[AW-1:0]];

    always_comb begin
        sumRow = '0;
        satRow = '0;
        for (int c = 0; c < NUM_COL; c++) begin
            sumRow[c*BW_ACCU +: BW_ACCU] = firstTile ? alignedRow[c*BW_ACCU +: BW_ACCU]
                : accRd[c*BW_ACCU +: BW_ACCU] + alignedRow[c*BW_ACCU +: BW_ACCU];
            if ($signed(sumRow[c*BW_ACCU +: BW_ACCU]) > SAT_MAX)
                satRow[c*BW_OUT +: BW_OUT] = SAT_MAX[BW_OUT-1:0];
            else if ($signed(sumRow[c*BW_ACCU +: BW_ACCU]) < SAT_MIN)
                satRow[c*BW_OUT +: BW_OUT] = SAT_MIN[BW_OUT-1:0];
            else
                satRow[c*BW_OUT +: BW_OUT] = sumRow[c*BW_ACCU +: BW_OUT];
        end
    end

    // A full FIFO still takes a push when the consumer pops in the same cycle.
    assign full   = (count_q == (FW+1)'(FIFO_DEPTH));
    assign pop    = out_valid && out_ready;
    assign push   = rowFire && lastTile && (!full || pop);
    assign drop   = rowFire && lastTile && full && !pop;
    assign accept = (state_q == IDLE) && start;

    always_ff @(posedge clk) begin
        if (rowFire && !lastTile) acc_q[rowCnt_q[AW-1:0]] <= sumRow;
        if (push) fifoMem_q[wrPtr_q] <= satRow;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (cfg_rows == '0 || cfg_tiles == 8'd0) ? DONE : COLLECT;
            COLLECT: if (rowFire && lastTile && lastRow) state_d = DRAIN;
            DRAIN:   if (count_q == '0) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rows_q     <= '0;
            tiles_q    <= '0;
            rowCnt_q   <= '0;
            tileCnt_q  <= '0;
            overflow_q <= 1'b0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rows_q     <= cfg_rows;
                tiles_q    <= cfg_tiles;
                rowCnt_q   <= '0;
                tileCnt_q  <= '0;
                overflow_q <= 1'b0;
            end else begin
                if (rowFire) begin
                    if (lastRow) begin
                        rowCnt_q  <= '0;
                        tileCnt_q <= tileCnt_q + 8'd1;
                    end else begin
                        rowCnt_q <= rowCnt_q + RW'(1);
                    end
                end
                if (drop) overflow_q <= 1'b1;
            end
            if (push) wrPtr_q <= wrPtr_q + FW'(1);
            if (pop)  rdPtr_q <= rdPtr_q + FW'(1);
            if (push && !pop)      count_q <= count_q + (FW+1)'(1);
            else if (pop && !push) count_q <= count_q - (FW+1)'(1);
        end
    end

    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? fifoMem_q[rdPtr_q] : '0;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_systolic_psum_collector.sv
// Directed self-checking bench for systolic_psum_collector: skewed row streaming,
// tile accumulation, saturation, FIFO overflow, degenerate/ignored starts and mid-job reset.
module tb_systolic_psum_collector;

    localparam int NC = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          start = 1'b0;
    logic [4:0]    cfg_rows = '0;
    logic [7:0]    cfg_tiles = '0;
    logic [127:0]  psum_in = '0;
    logic          psum_valid = 1'b0;
    logic [63:0]   out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          busy;
    logic          done;
    logic          overflow;

    int checks = 0;
    int errors = 0;
    int doneCount = 0;
    int firstValidT = -1;
    logic [63:0]        rowQ[$];
    logic signed [31:0] stim [0:15][0:3];

    systolic_psum_collector dut (
        .clk(clk), .reset_n(reset_n), .start(start), .cfg_rows(cfg_rows),
        .cfg_tiles(cfg_tiles), .psum_in(psum_in), .psum_valid(psum_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .overflow(overflow)
    );

    // Free-running clock, 10 ns period
    always #5 clk = ~clk;

    // Records every row the consumer accepts and every done cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (out_valid && out_ready) rowQ.push_back(out_data);
            if (done) doneCount++;
        end
    end

    function automatic logic [63:0] packRow(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    // Pulses start for one cycle with the given job configuration
    task automatic startJob(input int rows, input int tiles);
        @(posedge clk); #1;
        cfg_rows  = 5'(rows);
        cfg_tiles = 8'(tiles);
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    // Streams stim rows 0..n-1 back to back, column c delayed c cycles behind column 0
    task automatic applyStimulus(input int n);
        firstValidT = -1;
        for (int t = 0; t < n + NC; t++) begin
            @(posedge clk); #1;
            if (out_valid && firstValidT < 0) firstValidT = t;
            psum_valid = (t < n);
            for (int c = 0; c < NC; c++) begin
                if (t - c >= 0 && t - c < n) psum_in[c*32 +: 32] = stim[t-c][c];
                else                         psum_in[c*32 +: 32] = 32'd0;
            end
        end
    endtask

    // Waits a bounded number of cycles for the done counter to reach target
    task automatic waitDone(input int target, input string name);
        for (int i = 0; i < 300 && doneCount < target; i++) @(posedge clk);
        #1;
        checks++;
        if (doneCount < target) begin
            errors++;
            $display("[TB] FAIL %s_timeout: doneCount=%0d required=%0d", name, doneCount, target);
        end
    endtask

    // Asynchronous reset must clear every output
    task automatic test_reset;
        #2 reset_n = 1'b0;
        #10;
        checks++;
        if ({out_valid, busy, done, overflow} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b required 0000", {out_valid, busy, done, overflow});
        end
        checks++;
        if (out_data !== 64'd0) begin
            errors++;
            $display("[TB] FAIL reset_data: got %h required 0", out_data);
        end
        @(negedge clk) reset_n = 1'b1;
    endtask

    // Two rows, one tile: exact passthrough and first-output latency
    task automatic test_single_tile;
        int d0;
        logic [63:0] e0, e1;
        rowQ.delete();
        d0 = doneCount;
        out_ready = 1'b1;
        for (int m = 0; m < 2; m++)
            for (int c = 0; c < NC; c++) stim[m][c] = 10*m + c;
        startJob(2, 1);
        applyStimulus(2);
        waitDone(d0 + 1, "single");
        repeat (3) @(posedge clk); #1;
        checks++;
        if (firstValidT !== 4) begin
            errors++;
            $display("[TB] FAIL single_latency: got %0d required 4", firstValidT);
        end
        checks++;
        if (rowQ.size() !== 2) begin
            errors++;
            $display("[TB] FAIL single_rowcount: got %0d required 2", rowQ.size());
        end
        e0 = packRow(0, 1, 2, 3);
        e1 = packRow(10, 11, 12, 13);
        checks++;
        if (rowQ.size() < 1 || rowQ[0] !== e0) begin
            errors++;
            $display("[TB] FAIL single_row0: got %h required %h", (rowQ.size() > 0) ? rowQ[0] : 64'hx, e0);
        end
        checks++;
        if (rowQ.size() < 2 || rowQ[1] !== e1) begin
            errors++;
            $display("[TB] FAIL single_row1: got %h required %h", (rowQ.size() > 1) ? rowQ[1] : 64'hx, e1);
        end
        checks++;
        if (doneCount !== d0 + 1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_done: got done=%0d busy=%b required done=%0d busy=0",
                     doneCount - d0, busy, 1);
        end
    endtask

    // Three tiles of one row: 100+200+300, nothing emitted before the last tile
    task automatic test_accumulate;
        int d0;
        logic [63:0] e0;
        rowQ.delete();
        d0 = doneCount;
        for (int c = 0; c < NC; c++) begin
            stim[0][c] = 100;
            stim[1][c] = 200;
            stim[2][c] = 300;
        end
        startJob(1, 3);
        applyStimulus(3);
        waitDone(d0 + 1, "accum");
        e0 = packRow(600, 600, 600, 600);
        checks++;
        if (firstValidT !== 6) begin
            errors++;
            $display("[TB] FAIL accum_latency: got %0d required 6", firstValidT);
        end
        checks++;
        if (rowQ.size() !== 1 || rowQ[0] !== e0) begin
            errors++;
            $display("[TB] FAIL accum_row: got size=%0d row=%h required size=1 row=%h",
                     rowQ.size(), (rowQ.size() > 0) ? rowQ[0] : 64'hx, e0);
        end
    endtask

    // Two tiles pushing sums past both 16-bit limits
    task automatic test_saturation;
        int d0;
        logic [63:0] e0;
        rowQ.delete();
        d0 = doneCount;
        for (int m = 0; m < 2; m++) begin
            stim[m][0] = 30000;
            stim[m][1] = 30000;
            stim[m][2] = -30000;
            stim[m][3] = -30000;
        end
        startJob(1, 2);
        applyStimulus(2);
        waitDone(d0 + 1, "sat");
        e0 = packRow(32767, 32767, -32768, -32768);
        checks++;
        if (rowQ.size() !== 1 || rowQ[0] !== e0) begin
            errors++;
            $display("[TB] FAIL sat_row: got size=%0d row=%h required size=1 row=%h",
                     rowQ.size(), (rowQ.size() > 0) ? rowQ[0] : 64'hx, e0);
        end
    endtask

    // Six rows into a four-deep FIFO with the consumer stalled
    task automatic test_overflow;
        int d0;
        logic [63:0] e0, e3;
        rowQ.delete();
        d0 = doneCount;
        out_ready = 1'b0;
        for (int m = 0; m < 6; m++)
            for (int c = 0; c < NC; c++) stim[m][c] = 10*m + c;
        startJob(6, 1);
        applyStimulus(6);
        repeat (2) @(posedge clk); #1;
        checks++;
        if ({overflow, out_valid, busy} !== 3'b111) begin
            errors++;
            $display("[TB] FAIL ovf_flags: got ovf/valid/busy=%b required 111", {overflow, out_valid, busy});
        end
        out_ready = 1'b1;
        waitDone(d0 + 1, "ovf");
        e0 = packRow(0, 1, 2, 3);
        e3 = packRow(30, 31, 32, 33);
        checks++;
        if (rowQ.size() !== 4) begin
            errors++;
            $display("[TB] FAIL ovf_rowcount: got %0d required 4", rowQ.size());
        end
        checks++;
        if (rowQ.size() < 4 || rowQ[0] !== e0 || rowQ[3] !== e3) begin
            errors++;
            $display("[TB] FAIL ovf_rows: got first=%h last=%h required %h %h",
                     (rowQ.size() > 0) ? rowQ[0] : 64'hx, (rowQ.size() > 3) ? rowQ[3] : 64'hx, e0, e3);
        end
    endtask

    // Zero tiles: straight to DONE; the accepted start also clears sticky overflow
    task automatic test_degenerate;
        int d0;
        rowQ.delete();
        d0 = doneCount;
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL degen_ovf_before: got %b required 1", overflow);
        end
        startJob(3, 0);
        checks++;
        if ({done, busy, overflow} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL degen_done: got done/busy/ovf=%b required 110", {done, busy, overflow});
        end
        @(posedge clk); #1;
        checks++;
        if ({done, busy, out_valid} !== 3'b000 || doneCount !== d0 + 1 || rowQ.size() !== 0) begin
            errors++;
            $display("[TB] FAIL degen_after: got done/busy/valid=%b pulses=%0d rows=%0d required 000 1 0",
                     {done, busy, out_valid}, doneCount - d0, rowQ.size());
        end
    endtask

    // A start pulse while COLLECT is running must not disturb the job
    task automatic test_ignored_start;
        int d0;
        logic [63:0] e0, e1;
        rowQ.delete();
        d0 = doneCount;
        out_ready = 1'b1;
        stim[0][0] = 1;   stim[0][1] = 2;   stim[0][2] = 3;   stim[0][3] = 4;
        stim[1][0] = 5;   stim[1][1] = 6;   stim[1][2] = 7;   stim[1][3] = 8;
        stim[2][0] = 10;  stim[2][1] = 20;  stim[2][2] = 30;  stim[2][3] = 40;
        stim[3][0] = -50; stim[3][1] = -60; stim[3][2] = -70; stim[3][3] = -80;
        startJob(2, 2);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ign_busy: got %b required 1", busy);
        end
        startJob(1, 1);
        cfg_rows  = 5'd2;
        cfg_tiles = 8'd2;
        applyStimulus(4);
        waitDone(d0 + 1, "ign");
        repeat (3) @(posedge clk); #1;
        e0 = packRow(11, 22, 33, 44);
        e1 = packRow(-45, -54, -63, -72);
        checks++;
        if (rowQ.size() !== 2 || rowQ[0] !== e0 || rowQ[1] !== e1) begin
            errors++;
            $display("[TB] FAIL ign_rows: got size=%0d r0=%h r1=%h required 2 %h %h", rowQ.size(),
                     (rowQ.size() > 0) ? rowQ[0] : 64'hx, (rowQ.size() > 1) ? rowQ[1] : 64'hx, e0, e1);
        end
        checks++;
        if (doneCount !== d0 + 1) begin
            errors++;
            $display("[TB] FAIL ign_donecount: got %0d required 1", doneCount - d0);
        end
    endtask

    // Reset in the middle of COLLECT with rows queued, then a clean job
    task automatic test_reset_mid_job;
        int d0;
        out_ready = 1'b0;
        for (int m = 0; m < 6; m++)
            for (int c = 0; c < NC; c++) stim[m][c] = 1000 + m;
        startJob(6, 1);
        applyStimulus(3);
        checks++;
        if ({busy, out_valid} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL mid_prereset: got busy/valid=%b required 11", {busy, out_valid});
        end
        d0 = doneCount;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, busy, done, overflow} !== 4'b0000 || out_data !== 64'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset: got flags=%b data=%h required 0000 0",
                     {out_valid, busy, done, overflow}, out_data);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        checks++;
        if (doneCount !== d0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_after: got pulses=%0d valid=%b required 0 0", doneCount - d0, out_valid);
        end
        test_single_tile();
    endtask

    initial begin
        test_reset();
        test_single_tile();
        test_accumulate();
        test_saturation();
        test_overflow();
        test_degenerate();
        test_ignored_start();
        test_reset_mid_job();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
